// File: rtl/fp32_operand_assembler.sv
// rtl/fp32_operand_assembler.sv - frames UART bytes into FP32 alpha/bravo/acc operands for the MAC
module fp32_operand_assembler #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic        clk,
   input  logic        RSTL_I,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [31:0] mac_result,
   input  logic        mac_result_valid,
   output logic [31:0] alpha_o,
   output logic [31:0] bravo_o,
   output logic [31:0] acc_o,
   output logic        mac_valid_o,
   input  logic        mac_ready_i,
   output logic        busy_o,
   output logic        frame_err_o
);

   localparam int            TW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    HDR_FULL  = 8'hA5;
   localparam logic [7:0]    HDR_CHAIN = 8'h5A;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PRESENT} state_t;

   state_t        state;
   logic          mode_full;
   logic [3:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [31:0]   slot_a, slot_b, slot_c, stored_res;
   logic [31:0]   cur_slot, shifted, nxt_a, nxt_b, nxt_c;
   logic [3:0]    byte_cnt_inc;
   logic          last_byte;

   // Staging slots absorb payload; outputs only see them once the frame is complete.
   always_comb begin
      case (byte_cnt[3:2])
         2'd0:    cur_slot = slot_a;
         2'd1:    cur_slot = slot_b;
         default: cur_slot = slot_c;
      endcase
      shifted = BIG_ENDIAN ? {cur_slot[23:0], rx_data} : {rx_data, cur_slot[31:8]};
      nxt_a = slot_a;
      nxt_b = slot_b;
      nxt_c = slot_c;
      case (byte_cnt[3:2])
         2'd0:    nxt_a = shifted;
         2'd1:    nxt_b = shifted;
         default: nxt_c = shifted;
      endcase
      byte_cnt_inc = byte_cnt + 4'd1;
      last_byte    = (byte_cnt_inc == (mode_full ? 4'd12 : 4'd8));
   end

   always_ff @(posedge clk or negedge RSTL_I) begin
      if (!RSTL_I)               stored_res <= 32'd0;
      else if (mac_result_valid) stored_res <= mac_result;
   end

   always_ff @(posedge clk or negedge RSTL_I) begin
      if (!RSTL_I) begin
         state       <= S_IDLE;
         mode_full   <= 1'b0;
         byte_cnt    <= 4'd0;
         tmo_cnt     <= '0;
         slot_a      <= 32'd0;
         slot_b      <= 32'd0;
         slot_c      <= 32'd0;
         alpha_o     <= 32'd0;
         bravo_o     <= 32'd0;
         acc_o       <= 32'd0;
         mac_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  if (rx_data == HDR_FULL || rx_data == HDR_CHAIN) begin
                     mode_full <= (rx_data == HDR_FULL);
                     byte_cnt  <= 4'd0;
                     tmo_cnt   <= '0;
                     slot_a    <= 32'd0;
                     slot_b    <= 32'd0;
                     slot_c    <= 32'd0;
                     busy_o    <= 1'b1;
                     state     <= S_COLLECT;
                  end else begin
                     frame_err_o <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (rx_valid) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= byte_cnt_inc;
                  slot_a   <= nxt_a;
                  slot_b   <= nxt_b;
                  slot_c   <= nxt_c;
                  if (last_byte) begin
                     alpha_o     <= nxt_a;
                     bravo_o     <= nxt_b;
                     // a result landing with the final byte is newer than the stored one
                     acc_o       <= mode_full ? nxt_c :
                                    (mac_result_valid ? mac_result : stored_res);
                     mac_valid_o <= 1'b1;
                     state       <= S_PRESENT;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  busy_o      <= 1'b0;
                  frame_err_o <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_PRESENT: begin
               if (rx_valid) frame_err_o <= 1'b1;
               if (mac_ready_i) begin
                  mac_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
